// File: rtl/data_arith_extend_arbiter_pkg.sv
// Shared types and helpers for the extender arbiter and its response FIFO.
package data_arith_extend_arbiter_pkg;

  // Control bundle: single clock plus synchronous active-high reset.
  typedef struct packed {
    logic Clock;
    logic Reset;
  } Data_Control_Control_T;

  // Extension mode understood by the shared extender.
  typedef enum logic {
    Signed   = 1'b0,
    Unsigned = 1'b1
  } Data_Arith_SignedUnsigned_T;

  // Widest requester id and result the shared records can carry.
  localparam int MAX_ID_W   = 8;
  localparam int MAX_DATA_W = 32;

  // Index width for n entries, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold every value 0..n.
  function automatic int credit_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  // One stage of the tag pipeline running alongside the extender.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

  // A completed response: originating requester and extended result.
  typedef struct packed {
    logic [MAX_ID_W-1:0]   id;
    logic [MAX_DATA_W-1:0] data;
  } rsp_t;

endpackage

// File: rtl/data_arith_extend_arbiter_if.sv
// Requester, extender and response signals of the extender arbiter.
// Handshake rule for both req_* and rsp_*: a transfer happens on a rising
// clock edge where valid and ready are both 1; ready never depends on the
// consumer-side ready of the other channel.
interface data_arith_extend_arbiter_if
  import data_arith_extend_arbiter_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8,
  parameter int REQ_N = 2,
  parameter int ID_W  = id_width(REQ_N)
) ();

  logic [REQ_N-1:0]            req_valid;
  logic [REQ_N-1:0]            req_ready;
  logic [REQ_N-1:0][IN_W-1:0]  req_data;
  Data_Arith_SignedUnsigned_T  req_sign [REQ_N];

  logic [IN_W-1:0]             ext_in;
  Data_Arith_SignedUnsigned_T  ext_sign;
  logic [OUT_W-1:0]            ext_out;

  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [OUT_W-1:0]            rsp_data;
  logic [ID_W-1:0]             rsp_id;

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_sign, ext_out, rsp_ready,
    output req_ready, ext_in, ext_sign, rsp_valid, rsp_data, rsp_id
  );

  // Requesters, extender and response consumer side.
  modport master (
    output req_valid, req_data, req_sign, ext_out, rsp_ready,
    input  req_ready, ext_in, ext_sign, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/data_arith_extend_rsp_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count.
module data_arith_extend_rsp_fifo
  import data_arith_extend_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  Data_Control_Control_T          ctrl,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic [credit_width(DEPTH)-1:0] count,
  output logic                           empty
);

  localparam int AW = id_width(DEPTH);
  localparam int CW = credit_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array, written at the tail.
  always_ff @(posedge ctrl.Clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge ctrl.Clock) begin
    if (ctrl.Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_arith_extend_arbiter.sv
// Round-robin arbiter sharing one fixed-latency extender between requesters.
// Results are tagged with the requester id and queued in a response FIFO;
// issue is credit-limited so the FIFO can never overflow.
module data_arith_extend_arbiter
  import data_arith_extend_arbiter_pkg::*;
#(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 8,
  parameter int REQ_N  = 2,
  parameter int LAT    = 2,
  parameter int FIFO_D = 4
) (
  input  Data_Control_Control_T         ctrl,
  data_arith_extend_arbiter_if.slave    bus,
  output logic                          busy
);

  localparam int ID_W  = id_width(REQ_N);
  localparam int CNT_W = credit_width(FIFO_D);
  localparam int SUM_W = credit_width(FIFO_D + LAT);
  localparam int FW    = ID_W + OUT_W;

  logic             rst;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  g;
  logic             has_req;
  logic             credit_ok;
  logic             transfer;
  tag_t             tags [LAT];
  logic [SUM_W-1:0] inflight;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic [FW-1:0]    fifo_wdata;
  logic [FW-1:0]    fifo_rdata;
  rsp_t             head;
  logic             unused_bits;

  assign rst = ctrl.Reset;

  // Count tag stages still travelling through the extender.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + SUM_W'(tags[i].valid);
    end
  end

  // A pop in the current cycle is deliberately not credited.
  assign credit_ok = (inflight + SUM_W'(count)) < SUM_W'(FIFO_D);

  // Round-robin pick: first valid requester at or after ptr, then wrap.
  always_comb begin
    has_req = 1'b0;
    g       = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (!has_req && bus.req_valid[i] && (ID_W'(i) >= ptr)) begin
        has_req = 1'b1;
        g       = ID_W'(i);
      end
    end
    for (int i = 0; i < REQ_N; i++) begin
      if (!has_req && bus.req_valid[i] && (ID_W'(i) < ptr)) begin
        has_req = 1'b1;
        g       = ID_W'(i);
      end
    end
  end

  assign transfer = has_req & credit_ok & ~rst;

  // One-hot ready to the granted requester, extender driven only on transfer.
  always_comb begin
    bus.req_ready = '0;
    bus.ext_in    = '0;
    bus.ext_sign  = Signed;
    if (transfer) begin
      bus.req_ready[g] = 1'b1;
      bus.ext_in       = bus.req_data[g];
      bus.ext_sign     = bus.req_sign[g];
    end
  end

  // Advance the round-robin pointer and the tag pipeline.
  always_ff @(posedge ctrl.Clock) begin
    if (rst) begin
      ptr <= '0;
      for (int i = 0; i < LAT; i++) begin
        tags[i] <= '0;
      end
    end else begin
      tags[0] <= tag_t'{valid: transfer, id: MAX_ID_W'(g)};
      for (int i = 1; i < LAT; i++) begin
        tags[i] <= tags[i-1];
      end
      if (transfer) begin
        ptr <= (g == ID_W'(REQ_N - 1)) ? '0 : g + 1'b1;
      end
    end
  end

  // The last tag stage lines up with the extender result.
  assign fifo_wdata = {tags[LAT-1].id[ID_W-1:0], bus.ext_out};

  data_arith_extend_rsp_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_D)
  ) u_rsp_fifo (
    .ctrl  (ctrl),
    .push  (tags[LAT-1].valid),
    .wdata (fifo_wdata),
    .pop   (bus.rsp_ready),
    .rdata (fifo_rdata),
    .count (count),
    .empty (fifo_empty)
  );

  assign head = rsp_t'{id:   MAX_ID_W'(fifo_rdata[FW-1 -: ID_W]),
                       data: MAX_DATA_W'(fifo_rdata[OUT_W-1:0])};

  assign bus.rsp_valid = ~fifo_empty;
  assign bus.rsp_id    = head.id[ID_W-1:0];
  assign bus.rsp_data  = head.data[OUT_W-1:0];
  assign busy          = (inflight != '0) | (count != '0);

  // Record fields wider than this configuration needs are structurally zero.
  assign unused_bits = ^{tags[LAT-1].id >> ID_W, head.id >> ID_W, head.data >> OUT_W};

endmodule

// File: doc/data_arith_extend_arbiter.md
Name: data_arith_extend_arbiter

Overview:
- Shares one pipelined sign/zero extender between REQ_N requesters. Fixed latency LAT, one operation per cycle.
- Round-robin grant, valid/ready handshake on each requester.
- Tags every issued operation with its requester id through the extender pipeline. Completed results land in a small response FIFO.
- Credit-based issue: the FIFO can never overflow, so the extender needs no stall input. Sits between decode-side users of immediates and the shared Data_Arith_extend instance.

Parameters:
- IN_W, 4, requester operand width
- OUT_W, 8, extended result width (OUT_W >= IN_W)
- REQ_N, 2, number of requesters (>= 1)
- LAT, 2, extender latency in cycles; must match the instantiated extender
- FIFO_D, 4, response FIFO depth (>= 1); also total credit count
- ID_W (localparam), max(1, clog2(REQ_N)), requester id width

Ports:
- ctrl  input  Data_Control_Control_T  control bundle; Clock field is the single clock, Reset field is synchronous active-high reset
- req_valid  input  REQ_N  per-requester operand valid
- req_ready  output  REQ_N  per-requester accept; one-hot or zero
- req_data  input  REQ_N x IN_W  per-requester operand
- req_sign  input  REQ_N x Data_Arith_SignedUnsigned_T  per-requester extension mode
- ext_in  output  IN_W  operand to shared extender
- ext_sign  output  Data_Arith_SignedUnsigned_T  mode to shared extender
- ext_out  input  OUT_W  extender result
- rsp_valid  output  1  response FIFO non-empty
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  OUT_W  head result
- rsp_id  output  ID_W  requester index of head result
- busy  output  1  any operation in flight or buffered

Behaviour:
- Reset (Reset=1 at a rising Clock):
  - rr pointer becomes 0; tag pipeline valids cleared; FIFO emptied.
  - rsp_valid, busy and req_ready are all 0 in the following cycle.
  - req_ready is held 0 while Reset=1.
  - Reset mid-operation discards in-flight and buffered results; none ever appear after release.
- Credit:
  - inflight = number of valid tag stages; count = FIFO occupancy.
  - Issue is allowed iff inflight + count < FIFO_D.
  - A pop in the same cycle is not credited (conservative).
- Grant:
  - g = first index i in ptr, ptr+1, ... (mod REQ_N) with req_valid[i]=1.
  - req_ready[g]=1 iff issue is allowed; all other bits 0.
  - Combinational from req_valid, ptr and credit; never depends on rsp_ready.
- Transfer:
  - Occurs when req_valid[g] & req_ready[g].
  - At that edge ptr <= (g+1) mod REQ_N; otherwise ptr holds.
- Extender drive:
  - On a transfer cycle, ext_in = req_data[g] and ext_sign = req_sign[g].
  - Otherwise ext_in = 0 and ext_sign = Signed (don't-care, held at a constant).
- Tag pipeline:
  - LAT-stage shift register of {valid, id}, advancing every cycle.
  - Stage 0 loads {transfer, g}.
  - When the last stage is valid, ext_out in that cycle is the result for that tag.
- Push:
  - {id, ext_out} is written to the FIFO at the end of the cycle in which the last stage is valid.
  - Accept-to-rsp_valid latency is LAT+1 cycles when the FIFO is empty (LAT=2: accept in cycle t, rsp_valid in t+3).
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - rsp_valid = count != 0; pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop: count unchanged, valid at every occupancy including full.
  - Responses leave in issue order.
- busy = (inflight != 0) | (count != 0).
- Data is never modified: width and sign rules belong to the extender.

Decomposition:
- Shared package holds:
  - the credit/ID width helper function;
  - the tag struct {valid, id};
  - the response struct {id, data}.
- Existing Data_Control_Control and Data_Arith_SignedUnsigned definitions are reused.
- One sub-module: data_arith_extend_rsp_fifo, a parameterised synchronous FIFO (WIDTH, DEPTH) with count output, clocked from the same ctrl bundle.

Test Plan:
- Single issue: Reset released at cycle 2; req0 sends 4'ha Signed at cycle 3 with rsp_ready=1 -> rsp_valid only in cycle 6, rsp_data=8'hfa, rsp_id=0; busy 1 in cycles 4-6.
- Unsigned path: req1 sends 4'ha Unsigned, then 4'h5 Signed -> responses 8'h0a id 1, then 8'h05 id 1, in consecutive cycles.
- Fairness: both requesters hold valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1 from ptr 0; rsp_id sequence 0,1,0,1.
- Backpressure: rsp_ready=0, req0 streaming -> exactly 4 accepts, then req_ready=0 and FIFO count=4. Raising rsp_ready -> 4 responses in order, then req0 accepted again; no loss or duplication.
- Steady state at boundary: FIFO_D=4, rsp_ready=1, single requester streaming -> throughput is at least one result per 2 cycles, and count never exceeds 4 (checker asserts no push when full).
- Reset mid-flight: assert Reset with 2 in flight and 1 buffered -> next cycle rsp_valid=0 and busy=0. After release no stale response appears, and with both requesters valid req0 is granted first.
